// File: rtl/palette_pkg.sv
// Shared types, animation mode codes and the power-on palette used by color_palette.
package palette_pkg;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        rgb444_t body;
        rgb444_t head;
    } pal_entry_t;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_CYCLE  = 2'b10;

    // Reset contents; deeper palettes repeat this table every 8 entries.
    localparam pal_entry_t DEFAULT_PAL [8] = '{
        '{body: 12'h00F, head: 12'h448},
        '{body: 12'h0FF, head: 12'h06F},
        '{body: 12'hFF0, head: 12'hF80},
        '{body: 12'h4F0, head: 12'h080},
        '{body: 12'hC8F, head: 12'hF0F},
        '{body: 12'h088, head: 12'h048},
        '{body: 12'h808, head: 12'h408},
        '{body: 12'h88F, head: 12'h008}
    };

endpackage

// File: rtl/anim_prescaler.sv
// Animation timebase: free-running prescaler giving a one-cycle tick and a blink phase
// that flips on every tick.
module anim_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic phase
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/color_palette.sv
// Runtime-writable body/head colour palette with NUM_CH registered lookup channels,
// each able to run static, blink (head masked) or cycle (walk through entries) modes.
module color_palette
    import palette_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int NUM_ENTRY = 8,
    parameter int COLOR_W   = 12,
    parameter int TICK_DIV  = 25_000_000,
    localparam int AW       = $clog2(NUM_ENTRY)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [COLOR_W-1:0]        wr_body,
    input  logic [COLOR_W-1:0]        wr_head,
    input  logic [NUM_CH*AW-1:0]      ch_addr,
    input  logic [NUM_CH*2-1:0]       ch_mode,
    output logic [NUM_CH*COLOR_W-1:0] body_color,
    output logic [NUM_CH*COLOR_W-1:0] head_color,
    output logic                      tick
);

    logic                phase;
    logic [COLOR_W-1:0]  mem_body [NUM_ENTRY];
    logic [COLOR_W-1:0]  mem_head [NUM_ENTRY];

    anim_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .phase (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                mem_body[i] <= COLOR_W'(DEFAULT_PAL[i[2:0]].body);
                mem_head[i] <= COLOR_W'(DEFAULT_PAL[i[2:0]].head);
            end
        end else if (wr_en) begin
            mem_body[wr_addr] <= wr_body;
            mem_head[wr_addr] <= wr_head;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [AW-1:0]      base;
        logic [AW-1:0]      off;
        logic [AW-1:0]      idx;
        logic [1:0]         mode;
        logic               hit;
        logic [COLOR_W-1:0] rd_body;
        logic [COLOR_W-1:0] rd_head;
        logic [COLOR_W-1:0] body_q;
        logic [COLOR_W-1:0] head_q;

        assign base    = ch_addr[c*AW +: AW];
        assign mode    = ch_mode[c*2 +: 2];
        assign idx     = base + off;
        // Write-first: a same-cycle write to the entry being read is forwarded.
        assign hit     = wr_en && (wr_addr == idx);
        assign rd_body = hit ? wr_body : mem_body[idx];
        assign rd_head = hit ? wr_head : mem_head[idx];

        // Leaving cycle mode parks the offset so re-entry restarts at the base index.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                off <= '0;
            end else if (mode == MODE_CYCLE) begin
                if (tick) off <= off + AW'(1);
            end else begin
                off <= '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                body_q <= '0;
                head_q <= '0;
            end else begin
                body_q <= rd_body;
                head_q <= (mode == MODE_BLINK && phase) ? '0 : rd_head;
            end
        end

        assign body_color[c*COLOR_W +: COLOR_W] = body_q;
        assign head_color[c*COLOR_W +: COLOR_W] = head_q;
    end

endmodule

// File: tb/tb_color_palette.sv
// Self-checking bench for color_palette: directed scenarios plus randomized traffic,
// all compared against a cycle-count based reference model.
module tb_color_palette;

    localparam int NUM_CH    = 2;
    localparam int NUM_ENTRY = 8;
    localparam int COLOR_W   = 12;
    localparam int TICK_DIV  = 4;
    localparam int AW        = 3;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      wr_en = 1'b0;
    logic [AW-1:0]             wr_addr = '0;
    logic [COLOR_W-1:0]        wr_body = '0;
    logic [COLOR_W-1:0]        wr_head = '0;
    logic [NUM_CH*AW-1:0]      ch_addr = '0;
    logic [NUM_CH*2-1:0]       ch_mode = '0;
    logic [NUM_CH*COLOR_W-1:0] body_color;
    logic [NUM_CH*COLOR_W-1:0] head_color;
    logic                      tick;

    color_palette #(
        .NUM_CH(NUM_CH), .NUM_ENTRY(NUM_ENTRY), .COLOR_W(COLOR_W), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_body(wr_body),
        .wr_head(wr_head), .ch_addr(ch_addr), .ch_mode(ch_mode),
        .body_color(body_color), .head_color(head_color), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] def_body [0:7] = '{12'h00F, 12'h0FF, 12'hFF0, 12'h4F0,
                                    12'hC8F, 12'h088, 12'h808, 12'h88F};
    logic [11:0] def_head [0:7] = '{12'h448, 12'h06F, 12'hF80, 12'h080,
                                    12'hF0F, 12'h048, 12'h408, 12'h008};

    // Reference state: palette contents, edges since reset release, ticks spent in cycle mode.
    logic [11:0] m_body [0:7];
    logic [11:0] m_head [0:7];
    int          m_off  [0:1];
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] body_of(input int c);
        return body_color[c*COLOR_W +: COLOR_W];
    endfunction

    function automatic logic [11:0] head_of(input int c);
        return head_color[c*COLOR_W +: COLOR_W];
    endfunction

    function automatic int addr_of(input int c);
        return int'(ch_addr[c*AW +: AW]);
    endfunction

    function automatic int mode_of(input int c);
        return int'(ch_mode[c*2 +: 2]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_body", 32'(body_color), 32'h0);
        chk("rst_head", 32'(head_color), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_body", 32'(body_color), 32'h0);
        for (int i = 0; i < 8; i++) begin
            m_body[i] = def_body[i];
            m_head[i] = def_head[i];
        end
        m_off[0] = 0;
        m_off[1] = 0;
        cyc = 0;
        rst = 1'b0;
    endtask

    // One clock: predict from pre-edge inputs and model state, advance, then compare.
    task automatic step();
        logic [11:0] eb [0:1];
        logic [11:0] eh [0:1];
        bit          tick_pre;
        bit          phase_pre;
        int          idx;
        tick_pre  = (cyc % TICK_DIV) == TICK_DIV - 1;
        phase_pre = ((cyc / TICK_DIV) % 2) == 1;
        for (int c = 0; c < NUM_CH; c++) begin
            idx = (addr_of(c) + m_off[c]) % NUM_ENTRY;
            if (wr_en && int'(wr_addr) == idx) begin
                eb[c] = wr_body;
                eh[c] = wr_head;
            end else begin
                eb[c] = m_body[idx];
                eh[c] = m_head[idx];
            end
            if (mode_of(c) == 1 && phase_pre) eh[c] = 12'h000;
        end
        @(posedge clk);
        if (wr_en) begin
            m_body[wr_addr] = wr_body;
            m_head[wr_addr] = wr_head;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (mode_of(c) == 2) begin
                if (tick_pre) m_off[c] = (m_off[c] + 1) % NUM_ENTRY;
            end else begin
                m_off[c] = 0;
            end
        end
        cyc++;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("ch%0d_body@%0d", c, cyc), 32'(body_of(c)), 32'(eb[c]));
            chk($sformatf("ch%0d_head@%0d", c, cyc), 32'(head_of(c)), 32'(eh[c]));
        end
        chk($sformatf("tick@%0d", cyc), 32'(tick), 32'((cyc % TICK_DIV) == TICK_DIV - 1));
    endtask

    initial begin
        #2;
        do_reset();

        // Static lookup of two base indices.
        ch_addr = {3'd3, 3'd0};
        ch_mode = 4'b0000;
        step();
        chk("static_ch0_body", 32'(body_of(0)), 32'h00F);
        chk("static_ch0_head", 32'(head_of(0)), 32'h448);
        chk("static_ch1_body", 32'(body_of(1)), 32'h4F0);
        chk("static_ch1_head", 32'(head_of(1)), 32'h080);

        // Same-cycle write forwarding, then reset discards the write.
        wr_en = 1'b1; wr_addr = 3'd0; wr_body = 12'hABC; wr_head = 12'h123;
        step();
        chk("fwd_ch0_body", 32'(body_of(0)), 32'hABC);
        chk("fwd_ch0_head", 32'(head_of(0)), 32'h123);
        wr_en = 1'b0;
        step();
        do_reset();
        step();
        chk("post_rst_ch0_body", 32'(body_of(0)), 32'h00F);
        chk("post_rst_ch0_head", 32'(head_of(0)), 32'h448);

        // Blink on channel 0 over several phases.
        do_reset();
        ch_addr = {3'd3, 3'd1};
        ch_mode = 4'b0001;
        for (int i = 0; i < 17; i++) step();
        chk("blink_body", 32'(body_of(0)), 32'h0FF);

        // Cycle mode on channel 1 from base 6, then back to static.
        do_reset();
        ch_addr = {3'd6, 3'd1};
        ch_mode = 4'b1000;
        for (int i = 0; i < 16; i++) step();
        chk("cycle_body_after_4_ticks", 32'(body_of(1)), 32'h0FF);
        ch_mode = 4'b0000;
        step();
        step();
        chk("cycle_exit_body", 32'(body_of(1)), 32'h808);

        // Shared read of entry 5 with a write landing on a tick cycle.
        ch_addr = {3'd5, 3'd5};
        ch_mode = 4'b0001;
        for (int i = 0; i < 2 * TICK_DIV && (cyc % TICK_DIV) != TICK_DIV - 1; i++) step();
        wr_en = 1'b1; wr_addr = 3'd5; wr_body = 12'h5A5; wr_head = 12'h3C3;
        step();
        wr_en = 1'b0;
        step();
        chk("shared_ch0_body", 32'(body_of(0)), 32'h5A5);
        chk("shared_ch1_body", 32'(body_of(1)), 32'h5A5);
        chk("shared_ch1_head", 32'(head_of(1)), 32'h3C3);

        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, NUM_ENTRY - 1));
            wr_body = COLOR_W'($urandom);
            wr_head = COLOR_W'($urandom);
            if ($urandom_range(0, 7) == 0) ch_addr = 6'($urandom);
            if ($urandom_range(0, 9) == 0) ch_mode = 4'($urandom);
            step();
            if (i % 200 == 199) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
